// File: rtl/ucsbece154a_memarb_pkg.sv
// Shared encodings for the unified-memory arbiter: sequencer states and port owner.
package ucsbece154a_memarb_pkg;

  typedef enum logic [1:0] {
    arb_IDLE  = 2'd0,
    arb_READ  = 2'd1,
    arb_WRITE = 2'd2
  } arb_state_t;

  typedef enum logic {
    arb_own_core = 1'b0,
    arb_own_dma  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/ucsbece154a_memarb_pick.sv
// Grant selection between core and DMA inside the accept window.
module ucsbece154a_memarb_pick (
  input  logic i_core_req,
  input  logic i_dma_req,
  input  logic i_window,
  input  logic i_starve_max,
  output logic o_core_gnt,
  output logic o_dma_gnt
);

  // Core wins ties unless the DMA has already lost STARVE_MAX contested accepts.
  assign o_dma_gnt  = i_window & i_dma_req & (~i_core_req | i_starve_max);
  assign o_core_gnt = i_window & i_core_req & ~(i_dma_req & i_starve_max);

endmodule

// File: rtl/ucsbece154a_memarb.sv
// Arbiter and sequencer sharing the single unified memory port between the core and DMA.
module ucsbece154a_memarb
  import ucsbece154a_memarb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_t    r_state, w_state_nxt;
  arb_owner_t    r_owner, w_owner_nxt;
  logic [LW-1:0] r_lat_cnt, w_lat_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic          r_mem_en, w_en_nxt;
  logic          r_mem_we, w_we_nxt;
  logic [AW-1:0] r_mem_addr, w_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_wdata_nxt;

  logic w_read_last;
  logic w_window;
  logic w_core_gnt;
  logic w_dma_gnt;

  assign w_read_last = (r_state == arb_READ) && (r_lat_cnt == LAT_LAST);
  // Holding the window closed during reset forces both grants low.
  assign w_window = reset & ((r_state == arb_IDLE) || (r_state == arb_WRITE) || w_read_last);

  ucsbece154a_memarb_pick u_pick (
    .i_core_req   (core_req_i),
    .i_dma_req    (dma_req_i),
    .i_window     (w_window),
    .i_starve_max (r_starve_cnt == STARVE_TOP),
    .o_core_gnt   (w_core_gnt),
    .o_dma_gnt    (w_dma_gnt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_lat_nxt    = r_lat_cnt;
    w_starve_nxt = r_starve_cnt;
    w_en_nxt     = r_mem_en;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_mem_addr;
    w_wdata_nxt  = r_mem_wdata;

    if (r_state == arb_READ && !w_read_last) begin
      w_lat_nxt = r_lat_cnt + LW'(1);
    end

    if (w_window) begin
      if (w_dma_gnt) begin
        w_state_nxt  = dma_we_i ? arb_WRITE : arb_READ;
        w_owner_nxt  = arb_own_dma;
        w_lat_nxt    = '0;
        w_en_nxt     = 1'b1;
        w_we_nxt     = dma_we_i;
        w_addr_nxt   = dma_addr_i;
        w_wdata_nxt  = dma_wdata_i;
        w_starve_nxt = '0;
      end else if (w_core_gnt) begin
        w_state_nxt = core_we_i ? arb_WRITE : arb_READ;
        w_owner_nxt = arb_own_core;
        w_lat_nxt   = '0;
        w_en_nxt    = 1'b1;
        w_we_nxt    = core_we_i;
        w_addr_nxt  = core_addr_i;
        w_wdata_nxt = core_wdata_i;
        if (dma_req_i && r_starve_cnt != STARVE_TOP) begin
          w_starve_nxt = r_starve_cnt + SW'(1);
        end
      end else begin
        w_state_nxt = arb_IDLE;
        w_lat_nxt   = '0;
        w_en_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= arb_IDLE;
      r_owner      <= arb_own_core;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_mem_en     <= w_en_nxt;
      r_mem_we     <= w_we_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
    end
  end

  assign core_gnt_o    = w_core_gnt;
  assign dma_gnt_o     = w_dma_gnt;
  assign core_rvalid_o = w_read_last && (r_owner == arb_own_core);
  assign dma_rvalid_o  = w_read_last && (r_owner == arb_own_dma);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign dma_rdata_o   = dma_rvalid_o ? mem_rdata_i : '0;
  assign mem_en_o      = r_mem_en;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign busy_o        = (r_state != arb_IDLE);

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
// Directed self-checking bench for the unified-memory arbiter (default parameters).
module tb_ucsbece154a_memarb;

  logic        clk;
  logic        reset;
  logic        coreReq, coreWe, dmaReq, dmaWe;
  logic [31:0] coreAddr, coreWdata, dmaAddr, dmaWdata;
  logic        coreGnt, coreRvalid, dmaGnt, dmaRvalid;
  logic [31:0] coreRdata, dmaRdata;
  logic        memEn, memWe, busy;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        useModel;
  logic [31:0] fixedRdata;

  int checkCount = 0;
  int errorCount = 0;

  // Memory model: either a fixed word or an address-tagged word so read order is visible.
  assign memRdata = useModel ? (32'hA500_0000 ^ memAddr) : fixedRdata;

  ucsbece154a_memarb u_dut (
    .clk          (clk),
    .reset        (reset),
    .core_req_i   (coreReq),
    .core_we_i    (coreWe),
    .core_addr_i  (coreAddr),
    .core_wdata_i (coreWdata),
    .core_gnt_o   (coreGnt),
    .core_rvalid_o(coreRvalid),
    .core_rdata_o (coreRdata),
    .dma_req_i    (dmaReq),
    .dma_we_i     (dmaWe),
    .dma_addr_i   (dmaAddr),
    .dma_wdata_i  (dmaWdata),
    .dma_gnt_o    (dmaGnt),
    .dma_rvalid_o (dmaRvalid),
    .dma_rdata_o  (dmaRdata),
    .mem_en_o     (memEn),
    .mem_we_o     (memWe),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; the caller then drives inputs and checks at negedge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr, input logic [31:0] cData,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr, input logic [31:0] dData);
    coreReq = cReq; coreWe = cWe; coreAddr = cAddr; coreWdata = cData;
    dmaReq = dReq; dmaWe = dWe; dmaAddr = dAddr; dmaWdata = dData;
  endtask

  initial begin
    int starveModel;
    logic expDma;
    logic prevDma;
    reset = 1'b0;
    useModel = 1'b0;
    fixedRdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);

    // Reset state, with requests present
    nextCycle();
    @(negedge clk);
    checkOutput("rst_core_gnt", {31'b0, coreGnt}, 32'd0);
    checkOutput("rst_dma_gnt", {31'b0, dmaGnt}, 32'd0);
    checkOutput("rst_mem_en", {31'b0, memEn}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, memWe}, 32'd0);
    checkOutput("rst_mem_addr", memAddr, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;

    // Core read alone
    fixedRdata = 32'hDEADBEEF;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_c0_core_gnt", {31'b0, coreGnt}, 32'd1);
    checkOutput("rd_c0_mem_en", {31'b0, memEn}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_c1_mem_en", {31'b0, memEn}, 32'd1);
    checkOutput("rd_c1_addr", memAddr, 32'h100);
    checkOutput("rd_c1_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("rd_c1_busy", {31'b0, busy}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_c2_mem_en", {31'b0, memEn}, 32'd1);
    checkOutput("rd_c2_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("rd_c2_rdata", coreRdata, 32'hDEADBEEF);
    checkOutput("rd_c2_dma_rdata", dmaRdata, 32'h0);
    checkOutput("rd_c2_dma_rvalid", {31'b0, dmaRvalid}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_c3_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("rd_c3_mem_en", {31'b0, memEn}, 32'd0);
    checkOutput("rd_c3_busy", {31'b0, busy}, 32'd0);

    // Core write, then DMA write granted in the write cycle
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wr_c0_core_gnt", {31'b0, coreGnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hCAFE0001);
    @(negedge clk);
    checkOutput("wr_c1_mem_we", {31'b0, memWe}, 32'd1);
    checkOutput("wr_c1_addr", memAddr, 32'h40);
    checkOutput("wr_c1_wdata", memWdata, 32'h12345678);
    checkOutput("wr_c1_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("wr_c1_dma_gnt", {31'b0, dmaGnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wr_c2_mem_we", {31'b0, memWe}, 32'd1);
    checkOutput("wr_c2_addr", memAddr, 32'h80);
    checkOutput("wr_c2_wdata", memWdata, 32'hCAFE0001);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_c3_mem_we", {31'b0, memWe}, 32'd0);
    checkOutput("wr_c3_busy", {31'b0, busy}, 32'd0);

    // Contention: both hold read requests; expect CORE x4 then DMA x1, repeating
    starveModel = 0;
    prevDma = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int k = 0; k < 10; k++) begin
      expDma = (starveModel == 4);
      @(negedge clk);
      checkOutput($sformatf("ct%0d_core_gnt", k), {31'b0, coreGnt}, {31'b0, ~expDma});
      checkOutput($sformatf("ct%0d_dma_gnt", k), {31'b0, dmaGnt}, {31'b0, expDma});
      checkOutput($sformatf("ct%0d_starve", k), 32'(u_dut.r_starve_cnt), 32'(starveModel));
      if (k > 0) begin
        checkOutput($sformatf("ct%0d_dma_rvalid", k), {31'b0, dmaRvalid}, {31'b0, prevDma});
        checkOutput($sformatf("ct%0d_core_rvalid", k), {31'b0, coreRvalid}, {31'b0, ~prevDma});
      end
      starveModel = expDma ? 0 : starveModel + 1;
      prevDma = expDma;
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("ct%0d_gap_gnt", k), {30'b0, coreGnt, dmaGnt}, 32'd0);
      if (expDma) checkOutput($sformatf("ct%0d_starve_clr", k), 32'(u_dut.r_starve_cnt), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ct_last_dma_rvalid", {31'b0, dmaRvalid}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("ct_idle_busy", {31'b0, busy}, 32'd0);

    // Pipelined core reads presented in each final read cycle
    useModel = 1'b1;
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("pl%0d_gnt", i), {31'b0, coreGnt}, 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("pl%0d_rvalid", i), {31'b0, coreRvalid}, 32'd1);
        checkOutput($sformatf("pl%0d_rdata", i), coreRdata, 32'hA500_0000 ^ 32'(4 * (i - 1)));
        checkOutput($sformatf("pl%0d_busy_final", i), {31'b0, busy}, 32'd1);
      end
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("pl%0d_busy", i), {31'b0, busy}, 32'd1);
      checkOutput($sformatf("pl%0d_addr", i), memAddr, 32'(4 * i));
      checkOutput($sformatf("pl%0d_no_rvalid", i), {31'b0, coreRvalid}, 32'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("pl3_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("pl3_rdata", coreRdata, 32'hA500_0008);
    checkOutput("pl3_busy", {31'b0, busy}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("pl_idle_busy", {31'b0, busy}, 32'd0);

    // DMA burst of 8 back-to-back writes with the core idle
    nextCycle();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      @(negedge clk);
      checkOutput($sformatf("bu%0d_dma_gnt", i), {31'b0, dmaGnt}, 32'd1);
      checkOutput($sformatf("bu%0d_starve", i), 32'(u_dut.r_starve_cnt), 32'd0);
      if (i > 0) begin
        checkOutput($sformatf("bu%0d_mem_we", i), {31'b0, memWe}, 32'd1);
        checkOutput($sformatf("bu%0d_addr", i), memAddr, 32'h1000 + 32'(4 * (i - 1)));
        checkOutput($sformatf("bu%0d_wdata", i), memWdata, 32'hB000_0000 + 32'(i - 1));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("bu8_mem_we", {31'b0, memWe}, 32'd1);
    checkOutput("bu8_addr", memAddr, 32'h101C);
    nextCycle();
    @(negedge clk);
    checkOutput("bu9_mem_we", {31'b0, memWe}, 32'd0);

    // Reset asserted mid-read abandons the DMA access
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checkOutput("mr_dma_gnt", {31'b0, dmaGnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("mr_mem_en_now", {31'b0, memEn}, 32'd0);
    @(negedge clk);
    checkOutput("mr_busy", {31'b0, busy}, 32'd0);
    checkOutput("mr_dma_rvalid", {31'b0, dmaRvalid}, 32'd0);
    nextCycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mr_post%0d_rvalid", i), {31'b0, dmaRvalid}, 32'd0);
      checkOutput($sformatf("mr_post%0d_busy", i), {31'b0, busy}, 32'd0);
      checkOutput($sformatf("mr_post%0d_mem_en", i), {31'b0, memEn}, 32'd0);
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
